// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with a 2-entry skid buffer, registered ready, flush and stall counter.
// state | meaning
// EMPTY | no payload held; valid_o=0, ready_o=1
// ONE   | main holds the head payload; valid_o=1, ready_o=1
// FULL  | main holds the head, skid holds the next; valid_o=1, ready_o=0
module pipe_stage_buffer #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = (state_q != FULL);
  assign data_o      = valid_o ? main_q : BUBBLE;
  assign stall_cnt_o = cnt_q;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = data_i;
        end else if (in_xfer) begin
          skid_d  = data_i;
          state_d = FULL;
        end else if (out_xfer) begin
          main_d  = BUBBLE;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (ready_i) begin
          main_d  = skid_q;
          skid_d  = BUBBLE;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
        state_d = EMPTY;
      end
    endcase
    // Squash overrides any handshake; the pop still completes for downstream this cycle.
    if (flush_i) begin
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
      state_d = EMPTY;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_o && !ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed and randomized check of pipe_stage_buffer against a queue-based reference model.
module tb_pipe_stage_buffer;

  localparam int          W   = 16;
  localparam logic [15:0] BUB = 16'hDEAD;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, valid_i, ready_i;
  logic [W-1:0]  data_i;
  logic          ready_o, valid_o, ready_w, valid_w;
  logic [W-1:0]  data_o, data_w;
  logic [2:0]    stall_cnt_o;
  logic [15:0]   stall_w;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] mq[$];
  int unsigned  mcnt, mcnt_w;

  always #5 clk_i = ~clk_i;

  pipe_stage_buffer #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(3)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o));

  pipe_stage_buffer #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(16)) u_dut_wide (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_w),
    .data_i(data_i), .valid_o(valid_w), .ready_i(ready_i), .data_o(data_w),
    .stall_cnt_o(stall_w));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit in_x, out_x;
    if (!rst_i) begin
      mq.delete();
      mcnt   = 0;
      mcnt_w = 0;
    end else begin
      if (mq.size() > 0 && !ready_i) begin
        if (mcnt < 7) mcnt++;
        if (mcnt_w < 65535) mcnt_w++;
      end
      if (flush_i) mq.delete();
      else begin
        in_x  = valid_i && (mq.size() < 2);
        out_x = (mq.size() > 0) && ready_i;
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(data_i);
      end
    end
  endtask

  task automatic check_all();
    check("valid_o", {31'd0, valid_o}, {31'd0, mq.size() > 0});
    check("ready_o", {31'd0, ready_o}, {31'd0, mq.size() < 2});
    check("data_o", {16'd0, data_o}, {16'd0, (mq.size() > 0) ? mq[0] : BUB});
    check("stall_cnt", {29'd0, stall_cnt_o}, mcnt);
    check("data_o_wide", {16'd0, data_w}, {16'd0, (mq.size() > 0) ? mq[0] : BUB});
    check("stall_cnt_wide", {16'd0, stall_w}, mcnt_w);
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic vin,
                     input logic [W-1:0] din, input logic rdy);
    rst_i   = rst;
    flush_i = fl;
    valid_i = vin;
    data_i  = din;
    ready_i = rdy;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    mcnt = 0; mcnt_w = 0;
    #2;

    // reset held with valid_i asserted
    cyc(0, 0, 1, 16'h0055, 1);
    cyc(0, 0, 1, 16'h0055, 1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_data", {16'd0, data_o}, 32'h0000DEAD);
    check("rst_cnt", {29'd0, stall_cnt_o}, 32'd0);

    // streaming
    cyc(1, 0, 1, 16'h0011, 1);
    check("stream_11", {16'd0, data_o}, 32'h11);
    cyc(1, 0, 1, 16'h0022, 1);
    check("stream_22", {16'd0, data_o}, 32'h22);
    cyc(1, 0, 1, 16'h0033, 1);
    check("stream_33", {16'd0, data_o}, 32'h33);
    check("stream_ready", {31'd0, ready_o}, 32'd1);
    cyc(1, 0, 0, 16'h0000, 1);
    check("stream_drained", {31'd0, valid_o}, 32'd0);

    // back-pressure
    cyc(1, 0, 1, 16'h000A, 0);
    cyc(1, 0, 1, 16'h000B, 0);
    check("bp_ready_full", {31'd0, ready_o}, 32'd0);
    cyc(1, 0, 1, 16'h000C, 0);
    check("bp_hold_A", {16'd0, data_o}, 32'hA);
    cyc(1, 0, 0, 16'h0000, 1);
    check("bp_out_B", {16'd0, data_o}, 32'hB);
    check("bp_ready_again", {31'd0, ready_o}, 32'd1);
    cyc(1, 0, 0, 16'h0000, 1);
    check("bp_empty", {31'd0, valid_o}, 32'd0);

    // flush in FULL with a competing push
    cyc(1, 0, 1, 16'h000A, 0);
    cyc(1, 0, 1, 16'h000B, 0);
    cyc(1, 1, 1, 16'h000C, 0);
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_data", {16'd0, data_o}, 32'h0000DEAD);
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    cyc(1, 0, 0, 16'h0000, 1);
    check("flush_no_C", {31'd0, valid_o}, 32'd0);

    // counter saturation, then flush keeps it
    cyc(1, 0, 1, 16'h0077, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 16'h0000, 0);
    check("sat_7", {29'd0, stall_cnt_o}, 32'd7);
    cyc(1, 1, 0, 16'h0000, 0);
    check("sat_after_flush", {29'd0, stall_cnt_o}, 32'd7);

    // reset mid-stream
    cyc(1, 0, 1, 16'h00A1, 0);
    cyc(1, 0, 1, 16'h00B2, 0);
    cyc(0, 0, 0, 16'h0000, 1);
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_cnt", {29'd0, stall_cnt_o}, 32'd0);
    cyc(1, 0, 0, 16'h0000, 1);
    check("mid_rst_no_emit", {31'd0, valid_o}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) >= 3) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
          W'($urandom),
          ($urandom_range(99) < 55) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
